// File: rtl/addr_map_if.sv
// Valid/ready beat bus for addr_map_pipe: upstream channel addresses in, remapped addresses out.
// master = producer/consumer side (window generator + memory ports), slave = the mapper.
interface addr_map_if #(
  parameter int NCH = 3,
  parameter int AW  = 12,
  parameter int OPW = 6
) ();
  logic              in_valid;
  logic              in_ready;
  logic [NCH*AW-1:0] in_addr;
  logic [OPW-1:0]    instr_fb;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*AW-1:0] out_addr;
  logic              out_bypass;
  logic [NCH-1:0]    out_uflow;

  modport master (
    output in_valid, in_addr, instr_fb, out_ready,
    input  in_ready, out_valid, out_addr, out_bypass, out_uflow
  );

  modport slave (
    input  in_valid, in_addr, instr_fb, out_ready,
    output in_ready, out_valid, out_addr, out_bypass, out_uflow
  );
endinterface

// File: rtl/addr_map_pipe.sv
// Per-channel window address remapper: out_k = in_k - (k+1)*stride unless bypassed, with output
// register + 2-entry skid. Define ADDR_MAP_SAT_EN to clamp borrowing channels to 0 instead of wrapping.
module addr_map_pipe #(
  parameter int NCH       = 3,
  parameter int AW        = 12,
  parameter int STRIDE    = 9,
  parameter int OPW       = 6,
  parameter int BYPASS_OP = 5,
  parameter int SENTINEL  = 4091
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_ld,
  input  logic [AW-1:0] cfg_stride,
  addr_map_if.slave     bus,
  output logic [15:0]   bypass_cnt
);

  // Offset width holds (NCH)*(2^AW-1) without overflow.
  localparam int OW = AW + $clog2(NCH + 1);

  typedef struct packed {
    logic [NCH*AW-1:0] addr;
    logic              bypass;
    logic [NCH-1:0]    uflow;
  } beat_t;

  logic [AW-1:0] stride_q;
  beat_t         new_beat;
  beat_t         out_q;
  logic          out_valid_q;
  logic          in_ready_q;
  beat_t         skid_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    skid_cnt, cnt_next;
  logic          accept, out_free, push, pop;

  always_comb begin
    logic          byp;
    logic [AW-1:0] in_k;
    logic [OW-1:0] off_k;
    logic          borrow;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    new_beat = '0;
    in_k     = '0;
    off_k    = '0;
    borrow   = 1'b0;
    byp = (bus.instr_fb == OPW'(BYPASS_OP)) || (bus.in_addr[AW-1:0] == AW'(SENTINEL));
    new_beat.bypass = byp;
    for (int k = 0; k < NCH; k++) begin
      in_k  = bus.in_addr[k*AW +: AW];
      off_k = OW'(k + 1) * OW'(stride_q);
      if (byp) begin
        new_beat.addr[k*AW +: AW] = in_k;
      end else begin
        borrow                    = OW'(in_k) < off_k;
        new_beat.uflow[k]         = borrow;
        new_beat.addr[k*AW +: AW] = in_k - off_k[AW-1:0];
`ifdef ADDR_MAP_SAT_EN
        if (borrow) new_beat.addr[k*AW +: AW] = '0;
`endif
      end
    end
  end

  // The skid is always drained before a fresh beat may enter the output register, preserving order.
  assign accept   = bus.in_valid && in_ready_q;
  assign out_free = !out_valid_q || bus.out_ready;
  assign pop      = out_free && (skid_cnt != 2'd0);
  assign push     = accept && !(out_free && (skid_cnt == 2'd0));
  assign cnt_next = skid_cnt + {1'b0, push} - {1'b0, pop};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q    <= AW'(STRIDE);
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      skid_cnt    <= 2'd0;
      bypass_cnt  <= 16'd0;
    end else begin
      if (cfg_ld) stride_q <= cfg_stride;
      if (out_free) begin
        if (pop) begin
          out_q       <= skid_mem[rd_ptr];
          out_valid_q <= 1'b1;
        end else if (accept) begin
          out_q       <= new_beat;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push) wr_ptr <= ~wr_ptr;
      skid_cnt   <= cnt_next;
      in_ready_q <= (cnt_next != 2'd2);
      if (out_valid_q && bus.out_ready && out_q.bypass && (bypass_cnt != 16'hFFFF))
        bypass_cnt <= bypass_cnt + 16'd1;
    end
  end

  // NOTE: skid storage is data only and is not reset; skid_cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr] <= new_beat;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = out_q.addr;
  assign bus.out_bypass = out_q.bypass;
  assign bus.out_uflow  = out_q.uflow;

endmodule
